// File: rtl/scaled_frame_feeder_if.sv
// Bundle between the frame feeder, its pixel memory and the VGA pixel FIFO write port.
// master = feeder side, slave = memory/FIFO side.
interface scaled_frame_feeder_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 13
);
    logic              en;
    logic              full;
    logic [DATA_W-1:0] data_in;
    logic              tpg_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic              write_en;
    logic [DATA_W-1:0] data_out;
    logic              sof;
    logic              eol;
    logic [15:0]       frame_cnt;
    logic              busy;

    modport master (
        input  en, full, data_in, tpg_sel,
        output mem_addr, write_en, data_out, sof, eol, frame_cnt, busy
    );

    modport slave (
        output en, full, data_in, tpg_sel,
        input  mem_addr, write_en, data_out, sof, eol, frame_cnt, busy
    );
endinterface

// File: rtl/scaled_frame_feeder.sv
// Pixel-replicating frame fetcher into the VGA FIFO; DISPLAY_TPG_EN adds a colour-bar generator.
// Latency: write_en/data_out follow each mem_addr issue by exactly RD_LAT cycles.
// Backpressure: full stalls new issues and counters; fetches already in flight always retire.
module scaled_frame_feeder #(
    parameter int DATA_W      = 24,
    parameter int ADDR_W      = 13,
    parameter int SRC_W       = 80,
    parameter int SRC_H       = 60,
    parameter int H_SCALE     = 8,
    parameter int V_SCALE     = 8,
    parameter int RD_LAT      = 1,
    parameter int STARTUP_CYC = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    scaled_frame_feeder_if.master bus
);
    localparam int HW = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
    localparam int XW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int VW = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;
    localparam int YW = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int SW = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;

    typedef enum logic [1:0] {S_WAIT, S_RUN, S_HALT} state_t;

    state_t state, state_nxt;
    logic [SW-1:0]     start_cnt;
    logic [HW-1:0]     h_rep, h_nxt;
    logic [XW-1:0]     x_pos, x_nxt;
    logic [VW-1:0]     v_rep, v_nxt;
    logic [YW-1:0]     y_pos, y_nxt;
    logic [ADDR_W-1:0] line_base, base_nxt, mem_addr_q;
    logic [15:0]       frame_q, frame_nxt;
    logic              issue, busy_c, startup_done;
    logic              h_last, x_last, v_last, y_last, frame_last, at_origin;
    logic [RD_LAT-1:0] vld_pipe, sof_pipe, eol_pipe;

    assign startup_done = (start_cnt == SW'(STARTUP_CYC - 1));
    assign h_last     = (h_rep == HW'(H_SCALE - 1));
    assign x_last     = (x_pos == XW'(SRC_W - 1));
    assign v_last     = (v_rep == VW'(V_SCALE - 1));
    assign y_last     = (y_pos == YW'(SRC_H - 1));
    assign frame_last = h_last && x_last && v_last && y_last;
    assign at_origin  = (h_rep == '0) && (x_pos == '0) && (v_rep == '0) && (y_pos == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_WAIT;
        else     state <= state_nxt;
    end

    // en is only consulted at frame boundaries, so dropping it always finishes the frame
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:  if (startup_done) state_nxt = bus.en ? S_RUN : S_HALT;
            S_RUN:   if (issue && frame_last && !bus.en) state_nxt = S_HALT;
            S_HALT:  if (bus.en) state_nxt = S_RUN;
            default: state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        busy_c = (state == S_RUN);
        issue  = busy_c && !bus.full;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              start_cnt <= '0;
        else if (state == S_WAIT && !startup_done) start_cnt <= start_cnt + SW'(1);
    end

    always_comb begin
        h_nxt     = h_rep;
        x_nxt     = x_pos;
        v_nxt     = v_rep;
        y_nxt     = y_pos;
        base_nxt  = line_base;
        frame_nxt = frame_q;
        if (issue) begin
            h_nxt = h_last ? '0 : h_rep + HW'(1);
            if (h_last) begin
                x_nxt = x_last ? '0 : x_pos + XW'(1);
                if (x_last) begin
                    v_nxt = v_last ? '0 : v_rep + VW'(1);
                    if (v_last) begin
                        if (y_last) begin
                            y_nxt     = '0;
                            base_nxt  = '0;
                            frame_nxt = frame_q + 16'd1;
                        end else begin
                            y_nxt    = y_pos + YW'(1);
                            base_nxt = line_base + ADDR_W'(SRC_W);
                        end
                    end
                end
            end
        end
    end

    // mem_addr always shows the pending pixel's address; it counts as issued only when full=0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_rep      <= '0;
            x_pos      <= '0;
            v_rep      <= '0;
            y_pos      <= '0;
            line_base  <= '0;
            frame_q    <= '0;
            mem_addr_q <= '0;
        end else begin
            h_rep      <= h_nxt;
            x_pos      <= x_nxt;
            v_rep      <= v_nxt;
            y_pos      <= y_nxt;
            line_base  <= base_nxt;
            frame_q    <= frame_nxt;
            mem_addr_q <= base_nxt + ADDR_W'(x_nxt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            sof_pipe <= '0;
            eol_pipe <= '0;
        end else begin
            vld_pipe[0] <= issue;
            sof_pipe[0] <= issue && at_origin;
            eol_pipe[0] <= issue && h_last && x_last;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                sof_pipe[i] <= sof_pipe[i-1];
                eol_pipe[i] <= eol_pipe[i-1];
            end
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.write_en  = vld_pipe[RD_LAT-1];
    assign bus.sof       = sof_pipe[RD_LAT-1];
    assign bus.eol       = eol_pipe[RD_LAT-1];
    assign bus.frame_cnt = frame_q;
    assign bus.busy      = busy_c;

`ifdef DISPLAY_TPG_EN
    localparam int CH    = DATA_W / 3;
    localparam int OUT_W = SRC_W * H_SCALE;

    logic [2:0]        bar_now;
    logic [2:0]        bar_pipe [RD_LAT];
    logic [RD_LAT-1:0] tpg_pipe;

    // Bars ordered white..black map to inverted {G,R,B} index bits
    function automatic logic [DATA_W-1:0] bar_colour(input logic [2:0] b);
        logic [DATA_W-1:0] c;
        c = '0;
        for (int i = 0; i < CH; i++) begin
            c[DATA_W-1-i]        = ~b[1];
            c[DATA_W-1-CH-i]     = ~b[2];
            c[DATA_W-1-2*CH-i]   = ~b[0];
        end
        return c;
    endfunction

    assign bar_now = 3'(((int'(x_pos) * H_SCALE + int'(h_rep)) * 8) / OUT_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tpg_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) bar_pipe[i] <= '0;
        end else begin
            tpg_pipe[0] <= bus.tpg_sel;
            bar_pipe[0] <= bar_now;
            for (int i = 1; i < RD_LAT; i++) begin
                tpg_pipe[i] <= tpg_pipe[i-1];
                bar_pipe[i] <= bar_pipe[i-1];
            end
        end
    end

    assign bus.data_out = !vld_pipe[RD_LAT-1] ? '0 :
                          tpg_pipe[RD_LAT-1]  ? bar_colour(bar_pipe[RD_LAT-1]) : bus.data_in;
`else
    logic unused_tpg;
    assign unused_tpg   = bus.tpg_sel;
    assign bus.data_out = vld_pipe[RD_LAT-1] ? bus.data_in : '0;
`endif
endmodule
